// File: rtl/hsv_adjust_ctrl.sv
// HSV adjust control: frame-synchronous shadow/active configuration and a fixed
// 3-cycle hue-offset / saturation-gain / value-gain pipeline with delay-matched syncs.
module hsv_adjust_ctrl #(
  parameter int H_MAX  = 359,
  parameter int S_ONE  = 256,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [8:0]        cfg_wdata,
  input  logic [8:0]        i_hsv_h,
  input  logic [8:0]        i_hsv_s,
  input  logic [7:0]        i_hsv_v,
  input  logic              vs,
  input  logic              hs,
  input  logic              de,
  output logic [8:0]        o_hsv_h,
  output logic [8:0]        o_hsv_s,
  output logic [7:0]        o_hsv_v,
  output logic              o_vs,
  output logic              o_hs,
  output logic              o_de,
  output logic              cfg_pending,
  output logic              cfg_applied,
  output logic              cfg_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [8:0]  H_MAX9  = 9'(H_MAX);
  localparam logic [8:0]  S_ONE9  = 9'(S_ONE);
  localparam logic [9:0]  H_MAX10 = 10'(H_MAX);
  localparam logic [9:0]  H_MOD10 = 10'(H_MAX + 1);
  localparam logic [9:0]  S_ONE10 = 10'(S_ONE);
  localparam logic [8:0]  V_MAX9  = 9'd255;

  typedef enum logic {IDLE, PEND} state_t;

  state_t state_q, state_d;

  logic [8:0] sh_hue_q, sh_hue_d, sh_sg_q, sh_sg_d, sh_vg_q, sh_vg_d;
  logic       sh_en_q, sh_en_d;
  logic [8:0] act_hue_q, act_hue_d, act_sg_q, act_sg_d, act_vg_q, act_vg_d;
  logic       act_en_q, act_en_d;
  logic       applied_q, applied_d, err_q, err_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [2:0] vs_sr_q, vs_sr_d, hs_sr_q, hs_sr_d, de_sr_q, de_sr_d;

  logic [9:0]  s1_h_q, s1_h_d;
  logic [17:0] s1_s_q, s1_s_d;
  logic [16:0] s1_v_q, s1_v_d;
  logic        s1_byp_q, s1_byp_d;
  logic [8:0]  s2_h_q, s2_h_d, s2_s_q, s2_s_d;
  logic [7:0]  s2_v_q, s2_v_d;
  logic [8:0]  o_h_q, o_h_d, o_s_q, o_s_d;
  logic [7:0]  o_v_q, o_v_d;

  logic       vs_rise, commit, load;
  logic [8:0] h_cl, s_cl;
  logic [9:0] s_shift;
  logic [8:0] v_shift;

  // Config side: shadow writes, commit FSM, and the frame-boundary load.
  always_comb begin
    vs_rise   = vs & ~vs_sr_q[0];
    commit    = cfg_we && (cfg_addr == 2'd3) && cfg_wdata[1];
    load      = (state_q == PEND) && vs_rise && !commit;
    state_d   = state_q;
    sh_hue_d  = sh_hue_q;
    sh_sg_d   = sh_sg_q;
    sh_vg_d   = sh_vg_q;
    sh_en_d   = sh_en_q;
    act_hue_d = act_hue_q;
    act_sg_d  = act_sg_q;
    act_vg_d  = act_vg_q;
    act_en_d  = act_en_q;
    err_d     = 1'b0;
    applied_d = load;
    fcnt_d    = vs_rise ? fcnt_q + 1'b1 : fcnt_q;

    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          if (cfg_wdata <= H_MAX9) sh_hue_d = cfg_wdata;
          else                     err_d    = 1'b1;
        end
        2'd1: sh_sg_d = cfg_wdata;
        2'd2: sh_vg_d = cfg_wdata;
        default: sh_en_d = cfg_wdata[0];
      endcase
    end

    case (state_q)
      IDLE: if (commit) state_d = PEND;
      default: begin
        if (commit)       state_d = PEND;
        else if (vs_rise) state_d = IDLE;
      end
    endcase

    // The load uses the shadow values as they stood before this cycle's write.
    if (load) begin
      act_hue_d = sh_hue_q;
      act_sg_d  = sh_sg_q;
      act_vg_d  = sh_vg_q;
      act_en_d  = sh_en_q;
    end
  end

  // Pixel side: S1 clamp + arithmetic, S2 wrap/saturate, S3 de gating.
  always_comb begin
    vs_sr_d  = {vs_sr_q[1:0], vs};
    hs_sr_d  = {hs_sr_q[1:0], hs};
    de_sr_d  = {de_sr_q[1:0], de};
    h_cl     = (i_hsv_h > H_MAX9) ? H_MAX9 : i_hsv_h;
    s_cl     = (i_hsv_s > S_ONE9) ? S_ONE9 : i_hsv_s;
    s1_byp_d = !act_en_q;

    if (act_en_q) begin
      s1_h_d = {1'b0, h_cl} + {1'b0, act_hue_q};
      s1_s_d = {9'd0, s_cl} * {9'd0, act_sg_q};
      s1_v_d = {9'd0, i_hsv_v} * {8'd0, act_vg_q};
    end else begin
      s1_h_d = {1'b0, i_hsv_h};
      s1_s_d = {9'd0, i_hsv_s};
      s1_v_d = {9'd0, i_hsv_v};
    end

    s_shift = s1_s_q[17:8];
    v_shift = s1_v_q[16:8];
    if (s1_byp_q) begin
      s2_h_d = s1_h_q[8:0];
      s2_s_d = s1_s_q[8:0];
      s2_v_d = s1_v_q[7:0];
    end else begin
      s2_h_d = (s1_h_q > H_MAX10) ? 9'(s1_h_q - H_MOD10) : s1_h_q[8:0];
      s2_s_d = (s_shift > S_ONE10) ? S_ONE9 : s_shift[8:0];
      s2_v_d = (v_shift > V_MAX9) ? 8'd255 : v_shift[7:0];
    end

    o_h_d = de_sr_q[1] ? s2_h_q : 9'd0;
    o_s_d = de_sr_q[1] ? s2_s_q : 9'd0;
    o_v_d = de_sr_q[1] ? s2_v_q : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_hue_q  <= 9'd0;
      sh_sg_q   <= S_ONE9;
      sh_vg_q   <= S_ONE9;
      sh_en_q   <= 1'b0;
      act_hue_q <= 9'd0;
      act_sg_q  <= S_ONE9;
      act_vg_q  <= S_ONE9;
      act_en_q  <= 1'b0;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
      vs_sr_q   <= 3'd0;
      hs_sr_q   <= 3'd0;
      de_sr_q   <= 3'd0;
      s1_h_q    <= 10'd0;
      s1_s_q    <= 18'd0;
      s1_v_q    <= 17'd0;
      s1_byp_q  <= 1'b0;
      s2_h_q    <= 9'd0;
      s2_s_q    <= 9'd0;
      s2_v_q    <= 8'd0;
      o_h_q     <= 9'd0;
      o_s_q     <= 9'd0;
      o_v_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      sh_hue_q  <= sh_hue_d;
      sh_sg_q   <= sh_sg_d;
      sh_vg_q   <= sh_vg_d;
      sh_en_q   <= sh_en_d;
      act_hue_q <= act_hue_d;
      act_sg_q  <= act_sg_d;
      act_vg_q  <= act_vg_d;
      act_en_q  <= act_en_d;
      applied_q <= applied_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      vs_sr_q   <= vs_sr_d;
      hs_sr_q   <= hs_sr_d;
      de_sr_q   <= de_sr_d;
      s1_h_q    <= s1_h_d;
      s1_s_q    <= s1_s_d;
      s1_v_q    <= s1_v_d;
      s1_byp_q  <= s1_byp_d;
      s2_h_q    <= s2_h_d;
      s2_s_q    <= s2_s_d;
      s2_v_q    <= s2_v_d;
      o_h_q     <= o_h_d;
      o_s_q     <= o_s_d;
      o_v_q     <= o_v_d;
    end
  end

  assign o_hsv_h     = o_h_q;
  assign o_hsv_s     = o_s_q;
  assign o_hsv_v     = o_v_q;
  assign o_vs        = vs_sr_q[2];
  assign o_hs        = hs_sr_q[2];
  assign o_de        = de_sr_q[2];
  assign cfg_pending = (state_q == PEND);
  assign cfg_applied = applied_q;
  assign cfg_err     = err_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_hsv_adjust_ctrl.sv
// Bench for hsv_adjust_ctrl: a behavioural config/pixel model feeds a scoreboard
// queue that is compared against the DUT outputs three cycles later.
module tb_hsv_adjust_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [8:0]  cfg_wdata = 9'd0;
  logic [8:0]  i_hsv_h = 9'd0;
  logic [8:0]  i_hsv_s = 9'd0;
  logic [7:0]  i_hsv_v = 8'd0;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [8:0]  o_hsv_h, o_hsv_s;
  logic [7:0]  o_hsv_v;
  logic        o_vs, o_hs, o_de;
  logic        cfg_pending, cfg_applied, cfg_err;
  logic [15:0] frame_cnt;

  hsv_adjust_ctrl #(.H_MAX(359), .S_ONE(256), .FCNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .i_hsv_h(i_hsv_h), .i_hsv_s(i_hsv_s), .i_hsv_v(i_hsv_v), .vs(vs), .hs(hs), .de(de),
    .o_hsv_h(o_hsv_h), .o_hsv_s(o_hsv_s), .o_hsv_v(o_hsv_v), .o_vs(o_vs), .o_hs(o_hs),
    .o_de(o_de), .cfg_pending(cfg_pending), .cfg_applied(cfg_applied), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, s, v;
    logic vsx, hsx, dex;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_sh_off, m_sh_sg, m_sh_vg, m_act_off, m_act_sg, m_act_vg;
  logic m_sh_en, m_act_en, m_pend, m_vs_prev, e_applied, e_err;
  logic [15:0] m_fcnt;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_sh_off = 0; m_sh_sg = 256; m_sh_vg = 256; m_sh_en = 1'b0;
    m_act_off = 0; m_act_sg = 256; m_act_vg = 256; m_act_en = 1'b0;
    m_pend = 1'b0; m_vs_prev = 1'b0; m_fcnt = 16'd0;
    e_applied = 1'b0; e_err = 1'b0;
    sb.delete();
  endtask

  function automatic exp_t model_pix();
    exp_t e;
    int hh, ss, vv;
    hh = int'(i_hsv_h); ss = int'(i_hsv_s); vv = int'(i_hsv_v);
    if (m_act_en) begin
      if (hh > 359) hh = 359;
      if (ss > 256) ss = 256;
      hh = hh + m_act_off;
      if (hh > 359) hh = hh - 360;
      ss = (ss * m_act_sg) / 256;
      if (ss > 256) ss = 256;
      vv = (vv * m_act_vg) / 256;
      if (vv > 255) vv = 255;
    end
    if (!de) begin hh = 0; ss = 0; vv = 0; end
    e.h = hh; e.s = ss; e.v = vv; e.vsx = vs; e.hsx = hs; e.dex = de;
    return e;
  endfunction

  // One clock of stimulus: model the edge, then compare after it.
  task automatic apply_stimulus();
    exp_t e;
    logic commit, rise;
    commit = cfg_we && (cfg_addr == 2'd3) && cfg_wdata[1];
    rise   = vs && !m_vs_prev;
    sb.push_back(model_pix());
    e_applied = m_pend && rise && !commit;
    if (e_applied) begin
      m_act_off = m_sh_off; m_act_sg = m_sh_sg; m_act_vg = m_sh_vg; m_act_en = m_sh_en;
    end
    e_err = cfg_we && (cfg_addr == 2'd0) && (cfg_wdata > 9'd359);
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: if (cfg_wdata <= 9'd359) m_sh_off = int'(cfg_wdata);
        2'd1: m_sh_sg = int'(cfg_wdata);
        2'd2: m_sh_vg = int'(cfg_wdata);
        default: m_sh_en = cfg_wdata[0];
      endcase
    end
    if (commit) m_pend = 1'b1;
    else if (rise) m_pend = 1'b0;
    if (rise) m_fcnt = m_fcnt + 16'd1;
    m_vs_prev = vs;

    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      check_output("o_hsv_h", 32'(o_hsv_h), 32'(e.h));
      check_output("o_hsv_s", 32'(o_hsv_s), 32'(e.s));
      check_output("o_hsv_v", 32'(o_hsv_v), 32'(e.v));
      check_output("o_vs", 32'(o_vs), 32'(e.vsx));
      check_output("o_hs", 32'(o_hs), 32'(e.hsx));
      check_output("o_de", 32'(o_de), 32'(e.dex));
    end
    check_output("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    check_output("cfg_applied", 32'(cfg_applied), 32'(e_applied));
    check_output("cfg_err", 32'(cfg_err), 32'(e_err));
    check_output("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [8:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    apply_stimulus();
  endtask

  task automatic pixel(input int n, input logic [8:0] h, input logic [8:0] s, input logic [7:0] v,
                       input logic d);
    i_hsv_h = h; i_hsv_s = s; i_hsv_v = v; de = d;
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic vs_pulse();
    vs = 1'b1; apply_stimulus();
    vs = 1'b0; apply_stimulus();
  endtask

  // Asynchronous reset away from the clock edge; everything must clear at once.
  task automatic do_reset();
    vs = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_o_hsv_h", 32'(o_hsv_h), 32'd0);
    check_output("rst_o_hsv_s", 32'(o_hsv_s), 32'd0);
    check_output("rst_o_hsv_v", 32'(o_hsv_v), 32'd0);
    check_output("rst_o_syncs", 32'({o_vs, o_hs, o_de}), 32'd0);
    check_output("rst_pending", 32'(cfg_pending), 32'd0);
    check_output("rst_applied", 32'(cfg_applied), 32'd0);
    check_output("rst_err", 32'(cfg_err), 32'd0);
    check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Bypass with enable=0, syncs delay-matched.
    hs = 1'b1;
    pixel(4, 9'd123, 9'd45, 8'd67, 1'b1);
    hs = 1'b0;
    pixel(2, 9'd123, 9'd45, 8'd67, 1'b0);
    pixel(3, 9'd400, 9'd300, 8'd255, 1'b1);

    // Program gains, commit, apply at vs rise.
    pixel(1, 9'd0, 9'd0, 8'd0, 1'b0);
    cfg_write(2'd0, 9'd100);
    cfg_write(2'd1, 9'd384);
    cfg_write(2'd2, 9'd128);
    cfg_write(2'd3, 9'd3);
    vs_pulse();
    pixel(4, 9'd300, 9'd200, 8'd200, 1'b1);
    pixel(3, 9'd359, 9'd256, 8'd255, 1'b1);
    pixel(3, 9'd450, 9'd500, 8'd10, 1'b1);
    pixel(3, 9'd300, 9'd200, 8'd200, 1'b0);

    // Pending commit has no effect until the next frame start.
    do_reset();
    cfg_write(2'd0, 9'd90);
    cfg_write(2'd3, 9'd3);
    pixel(4, 9'd10, 9'd0, 8'd0, 1'b1);
    vs_pulse();
    pixel(4, 9'd10, 9'd0, 8'd0, 1'b1);

    // Rejected hue offset, value gain saturation.
    cfg_write(2'd0, 9'd400);
    cfg_write(2'd2, 9'd511);
    cfg_write(2'd3, 9'd3);
    vs_pulse();
    pixel(4, 9'd10, 9'd100, 8'd255, 1'b1);

    // Commit coincident with vs rise defers the load by a frame.
    cfg_write(2'd1, 9'd128);
    vs = 1'b1;
    cfg_write(2'd3, 9'd3);
    vs = 1'b0;
    pixel(4, 9'd10, 9'd200, 8'd100, 1'b1);
    vs_pulse();
    pixel(4, 9'd10, 9'd200, 8'd100, 1'b1);

    // Reset while PEND and mid-line discards the commit.
    cfg_write(2'd0, 9'd200);
    cfg_write(2'd3, 9'd3);
    pixel(2, 9'd50, 9'd100, 8'd100, 1'b1);
    do_reset();
    pixel(2, 9'd50, 9'd100, 8'd100, 1'b1);
    vs_pulse();
    pixel(4, 9'd50, 9'd100, 8'd100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
